// File: rtl/bullet_pkg.sv
// Shared types and lane geometry for the bullet subsystem (frame sequencer,
// shift-register bank and bullet drawer).
package bullet_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    DRAW_EN  = 3'd2,
    DRAW_GAP = 3'd3,
    DONE     = 3'd4
  } bfc_state_t;

  localparam int unsigned ROW_W          = 118;
  localparam int unsigned DEFAULT_ROWS   = 4;
  localparam int unsigned LANE_Y_BASE    = 8;
  localparam int unsigned LANE_ROW_PITCH = 16;

  // Screen y of a lane, wrapping modulo 256 like the 8-bit VGA row bus.
  function automatic logic [7:0] lane_y(input int unsigned row,
                                        input int unsigned base,
                                        input int unsigned pitch);
    int unsigned y;
    y = base + row * pitch;
    return y[7:0];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, on count TICK_DIV-1.
module tick_divider #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == CNT_W'(TICK_DIV - 1));
  assign tick   = w_wrap;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bullet_frame_ctrl.sv
// Bullet lane sequencer: shift tick, fire gating with per-lane cooldown, and
// row-by-row drawer handshake. Outputs are registered from next-state values.
module bullet_frame_ctrl
  import bullet_pkg::*;
#(
  parameter int unsigned ROWS           = DEFAULT_ROWS,
  parameter int unsigned TICK_DIV       = 25_000_000,
  parameter int unsigned COOLDOWN_TICKS = 2,
  parameter int unsigned Y_BASE         = LANE_Y_BASE,
  parameter int unsigned ROW_PITCH      = LANE_ROW_PITCH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire,
  input  logic [$clog2(ROWS)-1:0]  fire_row,
  output logic [ROWS-1:0]          shift_en,
  output logic [ROWS-1:0]          load,
  output logic                     serial_bit,
  output logic                     draw_en,
  output logic [$clog2(ROWS)-1:0]  draw_row,
  output logic [7:0]               draw_y,
  input  logic                     draw_done,
  output logic                     frame_done,
  output logic [7:0]               overrun
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

  bfc_state_t        r_state, w_state_nxt;
  logic [RW-1:0]     r_row, w_row_nxt;
  logic              r_pend, w_pend_nxt;
  logic [RW-1:0]     r_pend_row, w_pend_row_nxt;
  logic              r_tick_pend;
  logic [CW-1:0]     r_cool [ROWS];
  logic [CW-1:0]     w_cool_nxt [ROWS];
  logic [ROWS-1:0]   w_load_nxt;
  logic              w_start;
  logic              w_tick;
  logic              w_pend_eff;
  logic [RW-1:0]     w_pend_row_eff;

  logic [ROWS-1:0]   r_shift_en;
  logic [ROWS-1:0]   r_load;
  logic              r_serial_bit;
  logic              r_draw_en;
  logic [RW-1:0]     r_draw_row;
  logic [7:0]        r_draw_y;
  logic              r_frame_done;
  logic [7:0]        r_overrun;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // A fire arriving on the cycle that launches SHIFT still belongs to that SHIFT.
  assign w_pend_eff     = fire | r_pend;
  assign w_pend_row_eff = fire ? fire_row : r_pend_row;

  // Next-state, row index, lane loading and cooldown bookkeeping.
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_start        = 1'b0;
    w_load_nxt     = '0;
    w_cool_nxt     = r_cool;
    w_pend_nxt     = r_pend;
    w_pend_row_nxt = r_pend_row;

    case (r_state)
      IDLE: begin
        if (w_tick || r_tick_pend) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
          w_row_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT:   w_state_nxt = DRAW_EN;
      DRAW_EN: begin
        if (draw_done) begin
          w_state_nxt = DRAW_GAP;
        end else begin
          w_state_nxt = DRAW_EN;
        end
      end
      DRAW_GAP: begin
        if (r_row == RW'(ROWS - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_row_nxt   = r_row + RW'(1);
          w_state_nxt = DRAW_EN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      w_pend_nxt = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        if (w_pend_eff && (w_pend_row_eff == RW'(i)) && (r_cool[i] == '0)) begin
          w_load_nxt[i] = 1'b1;
          w_cool_nxt[i] = CW'(COOLDOWN_TICKS);
        end else if (r_cool[i] != '0) begin
          w_cool_nxt[i] = r_cool[i] - CW'(1);
        end else begin
          w_cool_nxt[i] = r_cool[i];
        end
      end
    end else if (fire) begin
      w_pend_nxt     = 1'b1;
      w_pend_row_nxt = fire_row;
    end else begin
      w_pend_nxt     = r_pend;
      w_pend_row_nxt = r_pend_row;
    end
  end

  // State, fire latch, cooldowns and overrun tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_pend      <= 1'b0;
      r_pend_row  <= '0;
      r_tick_pend <= 1'b0;
      r_overrun   <= 8'd0;
      for (int i = 0; i < ROWS; i++) begin
        r_cool[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_row <= w_pend_row_nxt;
      r_cool     <= w_cool_nxt;
      if (r_state == IDLE) begin
        r_tick_pend <= 1'b0;
      end else if (w_tick) begin
        r_tick_pend <= 1'b1;
      end else begin
        r_tick_pend <= r_tick_pend;
      end
      if (w_tick && (r_state != IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  // Output registers, loaded from the values of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift_en   <= '0;
      r_load       <= '0;
      r_serial_bit <= 1'b0;
      r_draw_en    <= 1'b0;
      r_draw_row   <= '0;
      r_draw_y     <= lane_y(32'd0, Y_BASE, ROW_PITCH);
      r_frame_done <= 1'b0;
    end else begin
      r_shift_en   <= w_start ? {ROWS{1'b1}} : {ROWS{1'b0}};
      r_load       <= w_load_nxt;
      r_serial_bit <= |w_load_nxt;
      r_draw_en    <= (w_state_nxt == DRAW_EN);
      r_draw_row   <= w_row_nxt;
      r_draw_y     <= lane_y(32'(w_row_nxt), Y_BASE, ROW_PITCH);
      r_frame_done <= (w_state_nxt == DONE);
    end
  end

  assign shift_en   = r_shift_en;
  assign load       = r_load;
  assign serial_bit = r_serial_bit;
  assign draw_en    = r_draw_en;
  assign draw_row   = r_draw_row;
  assign draw_y     = r_draw_y;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_bullet_frame_ctrl.sv
// Directed bench for bullet_frame_ctrl: TICK_DIV=8, two lanes, cooldown 2, drawer
// model raising done three cycles after draw_en. Cycle k = k clocks after reset release.
module tb_bullet_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       fire;
  logic [0:0] fire_row;
  logic [1:0] shift_en;
  logic [1:0] load;
  logic       serial_bit;
  logic       draw_en;
  logic [0:0] draw_row;
  logic [7:0] draw_y;
  logic       draw_done;
  logic       frame_done;
  logic [7:0] overrun;

  int         n_cmp;
  int         n_bad;
  int         cyc;
  logic       stall;
  logic [1:0] d_cnt;

  bullet_frame_ctrl #(
    .ROWS(2), .TICK_DIV(8), .COOLDOWN_TICKS(2), .Y_BASE(8), .ROW_PITCH(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fire       (fire),
    .fire_row   (fire_row),
    .shift_en   (shift_en),
    .load       (load),
    .serial_bit (serial_bit),
    .draw_en    (draw_en),
    .draw_row   (draw_row),
    .draw_y     (draw_y),
    .draw_done  (draw_done),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Drawer model: done three cycles after draw_en rises, held until draw_en falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_cnt     <= 2'd0;
      draw_done <= 1'b0;
    end else if (!draw_en) begin
      d_cnt     <= 2'd0;
      draw_done <= 1'b0;
    end else begin
      if (d_cnt != 2'd2) d_cnt <= d_cnt + 2'd1;
      draw_done <= (d_cnt == 2'd2) && !stall;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    fire     = 1'b0;
    fire_row = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_fire(input int c, input logic row);
    wait_cyc(c);
    fire     = 1'b1;
    fire_row = row;
    wait_cyc(c + 1);
    fire     = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0;
    reset = 1'b1;
    fire  = 1'b0;
    fire_row = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({shift_en, load, serial_bit, draw_en, draw_row, frame_done} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {shift_en, load, serial_bit, draw_en, draw_row, frame_done});
    end
    n_cmp++;
    if (draw_y !== 8'd8) begin
      n_bad++; $display("FAIL reset_draw_y: got %0d want 8", draw_y);
    end
    n_cmp++;
    if (overrun !== 8'd0) begin
      n_bad++; $display("FAIL reset_overrun: got %0d want 0", overrun);
    end
  endtask

  task automatic test_frame();
    stall = 1'b0;
    reset_dut();
    wait_cyc(7);
    n_cmp++;
    if (shift_en !== 2'b00) begin n_bad++; $display("FAIL frame_shift_c7: got %b want 00", shift_en); end
    wait_cyc(8);
    n_cmp++;
    if (shift_en !== 2'b11) begin n_bad++; $display("FAIL frame_shift_c8: got %b want 11", shift_en); end
    n_cmp++;
    if (load !== 2'b00) begin n_bad++; $display("FAIL frame_load_c8: got %b want 00", load); end
    wait_cyc(9);
    n_cmp++;
    if ({draw_en, draw_row, draw_y} !== {1'b1, 1'b0, 8'd8}) begin
      n_bad++; $display("FAIL frame_row0: got en=%b row=%0d y=%0d want en=1 row=0 y=8", draw_en, draw_row, draw_y);
    end
    wait_cyc(13);
    n_cmp++;
    if (draw_en !== 1'b0) begin n_bad++; $display("FAIL frame_gap0: got draw_en=%b want 0", draw_en); end
    wait_cyc(14);
    n_cmp++;
    if ({draw_en, draw_row, draw_y} !== {1'b1, 1'b1, 8'd24}) begin
      n_bad++; $display("FAIL frame_row1: got en=%b row=%0d y=%0d want en=1 row=1 y=24", draw_en, draw_row, draw_y);
    end
    n_cmp++;
    if (overrun !== 8'd0) begin n_bad++; $display("FAIL frame_overrun_c14: got %0d want 0", overrun); end
    wait_cyc(16);
    n_cmp++;
    if (overrun !== 8'd1) begin n_bad++; $display("FAIL frame_overrun_c16: got %0d want 1", overrun); end
    wait_cyc(18);
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_c18: got %b want 0", frame_done); end
    wait_cyc(19);
    n_cmp++;
    if (frame_done !== 1'b1) begin n_bad++; $display("FAIL frame_done_c19: got %b want 1", frame_done); end
    wait_cyc(20);
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_c20: got %b want 0", frame_done); end
  endtask

  task automatic test_cooldown();
    stall = 1'b0;
    reset_dut();
    pulse_fire(3, 1'b1);
    wait_cyc(8);
    n_cmp++;
    if ({load, serial_bit} !== 3'b101) begin
      n_bad++; $display("FAIL cool_first: got load=%b bit=%b want load=10 bit=1", load, serial_bit);
    end
    pulse_fire(10, 1'b1);
    wait_cyc(21);
    n_cmp++;
    if ({shift_en, load} !== 4'b1100) begin
      n_bad++; $display("FAIL cool_blocked: got shift=%b load=%b want shift=11 load=00", shift_en, load);
    end
    wait_cyc(34);
    n_cmp++;
    if ({shift_en, load} !== 4'b1100) begin
      n_bad++; $display("FAIL cool_idle_shift: got shift=%b load=%b want shift=11 load=00", shift_en, load);
    end
    pulse_fire(36, 1'b1);
    wait_cyc(47);
    n_cmp++;
    if ({shift_en, load, serial_bit} !== 5'b11101) begin
      n_bad++; $display("FAIL cool_expired: got shift=%b load=%b bit=%b want shift=11 load=10 bit=1",
                        shift_en, load, serial_bit);
    end
  endtask

  task automatic test_last_fire_wins();
    stall = 1'b0;
    reset_dut();
    pulse_fire(2, 1'b0);
    pulse_fire(4, 1'b1);
    wait_cyc(8);
    n_cmp++;
    if (load !== 2'b10) begin n_bad++; $display("FAIL last_wins: got load=%b want 10", load); end
  endtask

  task automatic test_fire_in_shift();
    stall = 1'b0;
    reset_dut();
    wait_cyc(8);
    n_cmp++;
    if ({shift_en, load} !== 4'b1100) begin
      n_bad++; $display("FAIL shiftfire_now: got shift=%b load=%b want shift=11 load=00", shift_en, load);
    end
    pulse_fire(8, 1'b0);
    wait_cyc(20);
    n_cmp++;
    if (shift_en !== 2'b00) begin n_bad++; $display("FAIL shiftfire_c20: got %b want 00", shift_en); end
    wait_cyc(21);
    n_cmp++;
    if ({shift_en, load} !== 4'b1101) begin
      n_bad++; $display("FAIL shiftfire_next: got shift=%b load=%b want shift=11 load=01", shift_en, load);
    end
  endtask

  task automatic test_stall_overrun();
    stall = 1'b1;
    reset_dut();
    wait_cyc(16);
    n_cmp++;
    if (overrun !== 8'd1) begin n_bad++; $display("FAIL stall_ovr1: got %0d want 1", overrun); end
    wait_cyc(24);
    n_cmp++;
    if (overrun !== 8'd2) begin n_bad++; $display("FAIL stall_ovr2: got %0d want 2", overrun); end
    wait_cyc(28);
    n_cmp++;
    if ({draw_en, draw_row, overrun} !== {1'b1, 1'b0, 8'd2}) begin
      n_bad++; $display("FAIL stall_hold: got en=%b row=%0d ovr=%0d want en=1 row=0 ovr=2", draw_en, draw_row, overrun);
    end
    stall = 1'b0;
    wait_cyc(36);
    n_cmp++;
    if (frame_done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", frame_done); end
    wait_cyc(37);
    n_cmp++;
    if ({shift_en, draw_en} !== 3'b000) begin
      n_bad++; $display("FAIL stall_idle: got shift=%b en=%b want shift=00 en=0", shift_en, draw_en);
    end
    wait_cyc(38);
    n_cmp++;
    if (shift_en !== 2'b11) begin n_bad++; $display("FAIL stall_extra_shift: got %b want 11", shift_en); end
  endtask

  task automatic test_reset_mid_frame();
    stall = 1'b0;
    reset_dut();
    wait_cyc(16);
    n_cmp++;
    if ({draw_en, draw_row, overrun} !== {1'b1, 1'b1, 8'd1}) begin
      n_bad++; $display("FAIL mid_pre: got en=%b row=%0d ovr=%0d want en=1 row=1 ovr=1", draw_en, draw_row, overrun);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({draw_en, draw_row, overrun} !== {1'b0, 1'b0, 8'd0}) begin
      n_bad++; $display("FAIL mid_async: got en=%b row=%0d ovr=%0d want en=0 row=0 ovr=0", draw_en, draw_row, overrun);
    end
    n_cmp++;
    if (draw_y !== 8'd8) begin n_bad++; $display("FAIL mid_draw_y: got %0d want 8", draw_y); end
    @(posedge clk);
    #1 reset = 1'b0;
    wait_cyc(7);
    n_cmp++;
    if (shift_en !== 2'b00) begin n_bad++; $display("FAIL mid_shift_c7: got %b want 00", shift_en); end
    wait_cyc(8);
    n_cmp++;
    if (shift_en !== 2'b11) begin n_bad++; $display("FAIL mid_shift_c8: got %b want 11", shift_en); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_frame();
    test_cooldown();
    test_last_fire_wins();
    test_fire_in_shift();
    test_stall_overrun();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at 1000000, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
